// File: rtl/aead_bus_pkg.sv
// Shared constants, command/decode types and address helpers for the aead_bus_seq register front-end.
package aead_bus_pkg;

  localparam logic [7:0]  ADDR_VERSION  = 8'h00;
  localparam logic [7:0]  ADDR_CTRL     = 8'h08;
  localparam logic [7:0]  ADDR_STATUS   = 8'h09;
  localparam logic [7:0]  ADDR_ERRCLR   = 8'h0A;
  localparam logic [3:0]  PAGE_CTX0_KEY = 4'h1;
  localparam logic [3:0]  PAGE_CTX0_NON = 4'h2;
  localparam logic [3:0]  PAGE_DATA     = 4'h3;
  localparam logic [3:0]  PAGE_CTXN_LO  = 4'h4;
  localparam logic [3:0]  PAGE_CTXN_HI  = 4'h6;
  localparam logic [3:0]  PAGE_RESULT   = 4'h8;
  localparam logic [31:0] VERSION_VALUE = 32'h0002_0000;
  localparam int          MAX_CTX       = 4;

  localparam logic [2:0] OP_INIT = 3'b001;
  localparam logic [2:0] OP_NEXT = 3'b010;
  localparam logic [2:0] OP_DONE = 3'b100;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_BAD_CMD  = 4;
  localparam int ST_WR_BUSY  = 5;
  localparam int ST_TIMEOUT  = 6;
  localparam int ST_COUNT    = 8;

  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_ISSUE = 2'd1;
  localparam logic [1:0] SEQ_WAIT  = 2'd2;

  typedef struct packed {
    logic [1:0] ctx;
    logic [2:0] op;
  } cmd_t;

  typedef struct packed {
    logic       hit;
    logic       is_key;
    logic [1:0] ctx;
    logic [2:0] idx;
  } ctx_sel_t;

  function automatic logic op_valid(input logic [2:0] op);
    return (op == OP_INIT) || (op == OP_NEXT) || (op == OP_DONE);
  endfunction

  // Maps an address onto a key/nonce slot; ctx range against NUM_CTX is checked by the caller.
  function automatic ctx_sel_t decode_ctx(input logic [7:0] a);
    ctx_sel_t d;
    d     = '0;
    d.idx = a[2:0];
    if (a[7:4] == PAGE_CTX0_KEY && !a[3]) begin
      d.hit    = 1'b1;
      d.is_key = 1'b1;
    end else if (a[7:4] == PAGE_CTX0_NON && a[3:0] < 4'd3) begin
      d.hit = 1'b1;
    end else if (a[7:4] >= PAGE_CTXN_LO && a[7:4] <= PAGE_CTXN_HI) begin
      d.ctx = 2'(a[7:4] - 4'h3);
      if (!a[3]) begin
        d.hit    = 1'b1;
        d.is_key = 1'b1;
      end else if (a[2:0] < 3'd3) begin
        d.hit = 1'b1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/aead_cmd_fifo.sv
// Command FIFO holding {ctx, op} entries; callers guarantee no push when full and no pop when empty.
module aead_cmd_fifo
  import aead_bus_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [4:0]                   wdata_i,
  output logic [4:0]                   rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(CMD_DEPTH):0]   count_o
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(CMD_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/aead_bus_seq.sv
// Register front-end and command sequencer for the ChaCha20-Poly1305 core.
// Define AEAD_BUS_TIMEOUT_EN to compile in the WAIT-state watchdog.
module aead_bus_seq
  import aead_bus_pkg::*;
#(
  parameter int NUM_CTX     = 2,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         we,
  input  logic [7:0]   address,
  input  logic [31:0]  write_data,
  output logic [31:0]  read_data,
  output logic         core_init,
  output logic         core_next,
  output logic         core_done,
  output logic [1:0]   core_ctx,
  output logic [255:0] core_key,
  output logic [95:0]  core_nonce,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [511:0] core_result
);
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  logic [31:0] key_q    [MAX_CTX][8];
  logic [31:0] nonce_q  [MAX_CTX][3];
  logic [31:0] data_q   [16];
  logic [31:0] result_q [16];

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  ctx_q, ctx_d;
  logic [ST_TIMEOUT:ST_OVERFLOW] sticky_q, sticky_d, sticky_set, sticky_clr;

  logic          wr, seq_active, ctx_ok, data_hit, ctx_active_hit;
  logic          key_we, nonce_we, data_we, ctrl_wr, cmd_ok, push, pop, latch, wd_expire;
  logic          fifo_full, fifo_empty;
  logic [4:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  cmd_t          fifo_cmd;
  ctx_sel_t      dec;
  logic [31:0]   status;

  assign wr             = cs && we;
  assign dec            = decode_ctx(address);
  assign ctx_ok         = dec.hit && (int'(dec.ctx) < NUM_CTX);
  assign data_hit       = (address[7:4] == PAGE_DATA);
  assign seq_active     = (state_q != SEQ_IDLE);
  assign ctx_active_hit = seq_active && ctx_ok && (dec.ctx == ctx_q);
  assign key_we         = wr && ctx_ok && dec.is_key && !ctx_active_hit;
  assign nonce_we       = wr && ctx_ok && !dec.is_key && !ctx_active_hit;
  assign data_we        = wr && data_hit && !seq_active;

  // Fullness uses the pre-pop count, so a same-cycle pop never makes room.
  assign ctrl_wr = wr && (address == ADDR_CTRL);
  assign cmd_ok  = op_valid(write_data[2:0]) && (int'(write_data[9:8]) < NUM_CTX);
  assign push    = ctrl_wr && cmd_ok && !fifo_full;
  assign pop     = (state_q == SEQ_IDLE) && !fifo_empty;

  aead_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({write_data[9:8], write_data[2:0]}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  assign fifo_cmd = cmd_t'(fifo_rdata);

`ifdef AEAD_BUS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != SEQ_WAIT) wd_q <= '0;
    else                              wd_q <= wd_q + WD_W'(1);
  end
  assign wd_expire = (state_q == SEQ_WAIT) && !core_ready && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  // TIMEOUT_CYC has no effect without the watchdog.
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctx_d   = ctx_q;
    latch   = 1'b0;
    case (state_q)
      SEQ_IDLE: if (!fifo_empty) begin
        state_d = SEQ_ISSUE;
        op_d    = fifo_cmd.op;
        ctx_d   = fifo_cmd.ctx;
      end
      SEQ_ISSUE: state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        if (core_ready) begin
          latch   = 1'b1;
          state_d = SEQ_IDLE;
        end else if (wd_expire) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Sticky set wins over a same-cycle ERRCLR.
  always_comb begin
    sticky_set              = '0;
    sticky_set[ST_OVERFLOW] = ctrl_wr && cmd_ok && fifo_full;
    sticky_set[ST_BAD_CMD]  = ctrl_wr && !cmd_ok;
    sticky_set[ST_WR_BUSY]  = wr && (ctx_active_hit || (data_hit && seq_active));
    sticky_set[ST_TIMEOUT]  = wd_expire;
    sticky_clr = (wr && address == ADDR_ERRCLR) ? write_data[ST_TIMEOUT:ST_OVERFLOW] : '0;
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      op_q     <= '0;
      ctx_q    <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctx_q    <= ctx_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < MAX_CTX; c++) begin
        for (int w = 0; w < 8; w++) key_q[c][w] <= '0;
        for (int w = 0; w < 3; w++) nonce_q[c][w] <= '0;
      end
      for (int w = 0; w < 16; w++) begin
        data_q[w]   <= '0;
        result_q[w] <= '0;
      end
    end else begin
      if (key_we)   key_q[dec.ctx][dec.idx]        <= write_data;
      if (nonce_we) nonce_q[dec.ctx][dec.idx[1:0]] <= write_data;
      if (data_we)  data_q[address[3:0]]           <= write_data;
      if (latch) begin
        for (int w = 0; w < 16; w++) result_q[w] <= core_result[511-32*w -: 32];
      end
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_BUSY]              = seq_active || !fifo_empty;
    status[ST_FULL]              = fifo_full;
    status[ST_EMPTY]             = fifo_empty;
    status[ST_TIMEOUT:ST_OVERFLOW] = sticky_q;
    status[ST_COUNT +: 5]        = 5'(fifo_count);
  end

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address == ADDR_VERSION)         read_data = VERSION_VALUE;
      else if (address == ADDR_STATUS)     read_data = status;
      else if (ctx_ok && dec.is_key)       read_data = key_q[dec.ctx][dec.idx];
      else if (ctx_ok)                     read_data = nonce_q[dec.ctx][dec.idx[1:0]];
      else if (data_hit)                   read_data = data_q[address[3:0]];
      else if (address[7:4] == PAGE_RESULT) read_data = result_q[address[3:0]];
    end
  end

  always_comb begin
    core_key   = '0;
    core_nonce = '0;
    core_block = '0;
    for (int w = 0; w < 8; w++)  core_key[255-32*w -: 32]  = key_q[ctx_q][w];
    for (int w = 0; w < 3; w++)  core_nonce[95-32*w -: 32] = nonce_q[ctx_q][w];
    for (int w = 0; w < 16; w++) core_block[511-32*w -: 32] = data_q[w];
  end

  assign core_init = (state_q == SEQ_ISSUE) && (op_q == OP_INIT);
  assign core_next = (state_q == SEQ_ISSUE) && (op_q == OP_NEXT);
  assign core_done = (state_q == SEQ_ISSUE) && (op_q == OP_DONE);
  assign core_ctx  = ctx_q;

endmodule
